// File: rtl/xband_rx_deframer_pkg.sv
// xband_pkg: shared K-char codes, receive FSM states and the FIFO word layout.
// Contents:
//   K_IDLE/K_SOF/K_EOF  framing K-char codes (any other K-char is treated as bad)
//   rx_state_t          receive FSM states
//   axis_word_t         one FIFO entry: payload, byte mask, last flag, error flag
//   keep_of()           byte mask for n valid bytes (n = 0..4)
package xband_pkg;

    localparam logic [7:0] K_IDLE = 8'hBC;
    localparam logic [7:0] K_SOF  = 8'hFB;
    localparam logic [7:0] K_EOF  = 8'hFD;

    typedef enum logic [1:0] {IDLE, DATA, DROP} rx_state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic        user;
    } axis_word_t;

    function automatic logic [3:0] keep_of(input logic [2:0] n);
        return 4'((5'd1 << n) - 5'd1);
    endfunction

endpackage

// File: rtl/xband_rx_deframer_if.sv
// xband_rx_deframer_if: AXI-Stream bundle carrying deframed 32-bit payload words.
// Signals:
//   tdata  32  payload, byte0 in [7:0]
//   tkeep  4   valid-byte mask, contiguous from bit0
//   tlast  1   last word of frame
//   tuser  1   frame terminated abnormally (tlast word only)
//   tvalid 1   word valid
//   tready 1   sink ready
interface xband_rx_deframer_if;

    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast;
    logic        tuser;
    logic        tvalid;
    logic        tready;

    modport master(output tdata, tkeep, tlast, tuser, tvalid, input tready);
    modport slave(input tdata, tkeep, tlast, tuser, tvalid, output tready);

endinterface

// File: rtl/xband_rx_deframer_word_fifo.sv
// xband_word_fifo: synchronous word FIFO of DEPTH entries with flop-backed output.
// Ports:
//   sys_clk, sys_rst_n  clock, asynchronous active-low reset
//   wr_en_i, wr_data_i  push request and word; ignored when full unless a pop happens
//   rd_en_i             pop request; ignored when empty
//   rd_data_o           head word, read straight from storage flops
//   full_o, empty_o     occupancy flags
module xband_word_fifo
    import xband_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       wr_en_i,
    input  axis_word_t wr_data_i,
    input  logic       rd_en_i,
    output axis_word_t rd_data_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    axis_word_t    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic          do_wr;
    logic          do_rd;

    assign full_o    = cnt_q == (AW+1)'(DEPTH);
    assign empty_o   = cnt_q == '0;
    assign do_rd     = rd_en_i && !empty_o;
    // A push into a full FIFO is accepted when the head leaves on the same edge.
    assign do_wr     = wr_en_i && (!full_o || do_rd);
    assign rd_data_o = mem_q[rd_ptr_q];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (do_wr) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end

endmodule

// File: rtl/xband_rx_deframer.sv
// xband_rx_deframer: strips Xband framing K-chars and packs payload into 32-bit AXI-Stream words.
// Ports:
//   sys_clk, sys_rst_n       byte clock, asynchronous active-low reset
//   rxdata/rxctrl/rxvalid    decoded byte, K-char flag, byte strobe (no backpressure)
//   exp_bytes                expected payload bytes per frame, 0 disables the length check
//   m_axis                   AXI-Stream master (tdata/tkeep/tlast/tuser/tvalid/tready)
//   frame_bytes              payload byte count of the last closed frame
//   frame_cnt                good frames, wrapping
//   err_cnt                  errored frames (abnormal end, length mismatch, runt), saturating
//   len_err                  sticky length mismatch
//   fifo_overflow            sticky: a word was dropped because the FIFO was full
module xband_rx_deframer
    import xband_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [7:0]           rxdata,
    input  logic                 rxctrl,
    input  logic                 rxvalid,
    input  logic [31:0]          exp_bytes,
    xband_rx_deframer_if.master  m_axis,
    output logic [31:0]          frame_bytes,
    output logic [CNT_W-1:0]     frame_cnt,
    output logic [CNT_W-1:0]     err_cnt,
    output logic                 len_err,
    output logic                 fifo_overflow
);

    rx_state_t        state_q;
    logic [31:0]      stage_q;
    logic [2:0]       stage_n_q;
    logic [31:0]      byte_cnt_q;
    logic             push_q;
    axis_word_t       push_word_q;
    logic [31:0]      frame_bytes_q;
    logic [CNT_W-1:0] frame_cnt_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic             len_err_q;
    logic             ovf_q;

    logic             is_data;
    logic             is_sof;
    logic             is_eof;
    logic             is_close;
    logic             len_bad_d;
    logic [CNT_W-1:0] err_inc_d;
    logic             full;
    logic             empty;
    logic             pop;
    axis_word_t       rd_word;

    assign is_data   = rxvalid && !rxctrl;
    assign is_sof    = rxvalid && rxctrl && rxdata == K_SOF;
    assign is_eof    = rxvalid && rxctrl && rxdata == K_EOF;
    // Every K-char except idle terminates an open frame; only EOF does so cleanly.
    assign is_close  = rxvalid && rxctrl && rxdata != K_IDLE;
    assign len_bad_d = exp_bytes != '0 && byte_cnt_q != exp_bytes;
    assign err_inc_d = (&err_cnt_q) ? err_cnt_q : err_cnt_q + 1'b1;
    assign pop       = m_axis.tready && !empty;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= IDLE;
            stage_q       <= '0;
            stage_n_q     <= '0;
            byte_cnt_q    <= '0;
            push_q        <= 1'b0;
            push_word_q   <= '0;
            frame_bytes_q <= '0;
            frame_cnt_q   <= '0;
            err_cnt_q     <= '0;
            len_err_q     <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            push_q <= 1'b0;
            if (push_q && full && !pop) ovf_q <= 1'b1;
            case (state_q)
                IDLE, DROP: begin
                    if (is_sof) begin
                        state_q    <= DATA;
                        stage_q    <= '0;
                        stage_n_q  <= '0;
                        byte_cnt_q <= '0;
                    end
                end
                DATA: begin
                    if (is_data) begin
                        // A full word waits in staging so the closing K-char can still mark it last.
                        if (stage_n_q == 3'd4) begin
                            push_q      <= 1'b1;
                            push_word_q <= '{data: stage_q, keep: 4'hF, last: 1'b0, user: 1'b0};
                            stage_q     <= {24'h0, rxdata};
                            stage_n_q   <= 3'd1;
                        end else begin
                            stage_q[8*stage_n_q[1:0] +: 8] <= rxdata;
                            stage_n_q                      <= stage_n_q + 3'd1;
                        end
                        byte_cnt_q <= byte_cnt_q + 32'd1;
                    end else if (is_close) begin
                        push_q        <= stage_n_q != '0;
                        push_word_q   <= '{data: stage_q, keep: keep_of(stage_n_q), last: 1'b1, user: !is_eof};
                        frame_bytes_q <= byte_cnt_q;
                        if (stage_n_q == '0) begin
                            err_cnt_q <= err_inc_d;
                        end else begin
                            if (len_bad_d) len_err_q <= 1'b1;
                            if (!is_eof || len_bad_d) err_cnt_q <= err_inc_d;
                            else frame_cnt_q <= frame_cnt_q + 1'b1;
                        end
                        stage_q    <= '0;
                        stage_n_q  <= '0;
                        byte_cnt_q <= '0;
                        state_q    <= is_eof ? IDLE : is_sof ? DATA : DROP;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    xband_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .wr_en_i   (push_q),
        .wr_data_i (push_word_q),
        .rd_en_i   (pop),
        .rd_data_o (rd_word),
        .full_o    (full),
        .empty_o   (empty)
    );

    assign m_axis.tdata  = rd_word.data;
    assign m_axis.tkeep  = rd_word.keep;
    assign m_axis.tlast  = rd_word.last;
    assign m_axis.tuser  = rd_word.user;
    assign m_axis.tvalid = !empty;

    assign frame_bytes   = frame_bytes_q;
    assign frame_cnt     = frame_cnt_q;
    assign err_cnt       = err_cnt_q;
    assign len_err       = len_err_q;
    assign fifo_overflow = ovf_q;

endmodule

// File: tb/tb_xband_rx_deframer.sv
// tb_xband_rx_deframer: directed and randomized checks of the deframer against a frame-level model.
module tb_xband_rx_deframer;
    import xband_pkg::*;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [7:0]  rxdata    = '0;
    logic        rxctrl    = 1'b0;
    logic        rxvalid   = 1'b0;
    logic [31:0] exp_bytes = '0;
    logic [31:0] frame_bytes;
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;
    logic        len_err;
    logic        fifo_overflow;

    xband_rx_deframer_if m_axis();

    xband_rx_deframer #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .rxdata        (rxdata),
        .rxctrl        (rxctrl),
        .rxvalid       (rxvalid),
        .exp_bytes     (exp_bytes),
        .m_axis        (m_axis),
        .frame_bytes   (frame_bytes),
        .frame_cnt     (frame_cnt),
        .err_cnt       (err_cnt),
        .len_err       (len_err),
        .fifo_overflow (fifo_overflow)
    );

    always #5 sys_clk = ~sys_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Frame-level model: payload bytes not yet emitted, expected words, expected status.
    bit          model_on = 1'b1;
    bit          in_frame;
    logic [31:0] nbytes;
    logic [7:0]  cur[$];
    logic [37:0] exp_q[$];
    logic [37:0] got[$];
    logic [31:0] m_fb;
    logic [15:0] m_fc;
    logic [15:0] m_ec;
    logic        m_le;
    int          ready_mode = 0;
    logic [7:0]  bad_k [5] = '{8'hF7, 8'h1C, 8'h3C, 8'h7C, 8'hFE};

    logic [37:0] prev_w;
    logic        prev_v = 1'b0;
    logic        prev_r = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        in_frame = 1'b0;
        nbytes   = '0;
        cur.delete();
        exp_q.delete();
        got.delete();
        m_fb = '0;
        m_fc = '0;
        m_ec = '0;
        m_le = 1'b0;
    endtask

    task automatic emit(input logic last, input logic user);
        logic [31:0] d;
        d = '0;
        for (int i = 0; i < cur.size(); i++) d |= 32'(cur[i]) << (8 * i);
        exp_q.push_back({d, 4'((1 << cur.size()) - 1), last, user});
        cur.delete();
    endtask

    task automatic close_frame(input logic user, input logic [31:0] exp_n);
        logic bad_len;
        m_fb = nbytes;
        if (nbytes == 0) begin
            if (m_ec != 16'hFFFF) m_ec++;
        end else begin
            emit(1'b1, user);
            bad_len = exp_n != 0 && nbytes != exp_n;
            if (bad_len) m_le = 1'b1;
            if (user || bad_len) begin
                if (m_ec != 16'hFFFF) m_ec++;
            end else begin
                m_fc++;
            end
        end
        nbytes = '0;
    endtask

    task automatic model_byte(input logic [7:0] d, input logic k, input logic [31:0] exp_n);
        if (!k) begin
            if (in_frame) begin
                if (cur.size() == 4) emit(1'b0, 1'b0);
                cur.push_back(d);
                nbytes++;
            end
        end else if (d == K_SOF) begin
            if (in_frame) close_frame(1'b1, exp_n);
            in_frame = 1'b1;
            nbytes   = '0;
            cur.delete();
        end else if (d == K_EOF) begin
            if (in_frame) close_frame(1'b0, exp_n);
            in_frame = 1'b0;
        end else if (d != K_IDLE) begin
            if (in_frame) close_frame(1'b1, exp_n);
            in_frame = 1'b0;
        end
    endtask

    always @(posedge sys_clk)
        if (sys_rst_n && model_on && rxvalid) model_byte(rxdata, rxctrl, exp_bytes);

    always @(posedge sys_clk) begin
        #1;
        m_axis.tready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? ($urandom_range(0, 7) != 0) : 1'b0;
    end

    always @(negedge sys_clk) begin
        logic [37:0] w;
        w = {m_axis.tdata, m_axis.tkeep, m_axis.tlast, m_axis.tuser};
        if (sys_rst_n) begin
            if (prev_v && !prev_r) chk("axis_hold", {m_axis.tvalid, w}, {1'b1, prev_w});
            if (m_axis.tvalid && m_axis.tready) begin
                got.push_back(w);
                if (model_on) begin
                    chk("axis_expected", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) chk("axis_word", w, exp_q.pop_front());
                end
            end
            if (model_on) begin
                chk("frame_bytes", frame_bytes, m_fb);
                chk("frame_cnt", frame_cnt, m_fc);
                chk("err_cnt", err_cnt, m_ec);
                chk("len_err", len_err, m_le);
                chk("fifo_overflow", fifo_overflow, 1'b0);
            end
        end
        prev_v = sys_rst_n && m_axis.tvalid;
        prev_r = m_axis.tready;
        prev_w = w;
    end

    task automatic put(input logic v, input logic k, input logic [7:0] d);
        rxvalid = v;
        rxctrl  = k;
        rxdata  = d;
        @(posedge sys_clk);
        #1;
        rxvalid = 1'b0;
    endtask

    task automatic kc(input logic [7:0] d);
        put(1'b1, 1'b1, d);
    endtask

    task automatic db(input logic [7:0] d);
        put(1'b1, 1'b0, d);
    endtask

    task automatic do_reset();
        rxvalid   = 1'b0;
        sys_rst_n = 1'b0;
        model_clear();
        @(posedge sys_clk);
        #1;
        @(posedge sys_clk);
        #2;
        sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic drain();
        int i;
        ready_mode = 0;
        for (i = 0; i < 200; i++) begin
            @(negedge sys_clk);
            if (exp_q.size() == 0 && !m_axis.tvalid) break;
        end
        chk("drain_done", exp_q.size() == 0 && !m_axis.tvalid, 1'b1);
        @(posedge sys_clk);
        #1;
    endtask

    function automatic logic [63:0] got_at(input int i);
        return i < got.size() ? 64'(got[i]) : '1;
    endfunction

    initial begin
        m_axis.tready = 1'b0;
        do_reset();
        chk("rst_tvalid", m_axis.tvalid, 1'b0);
        chk("rst_frame_cnt", frame_cnt, 16'd0);
        chk("rst_err_cnt", err_cnt, 16'd0);
        chk("rst_frame_bytes", frame_bytes, 32'd0);
        chk("rst_flags", {len_err, fifo_overflow}, 2'b00);

        // Two full words, tlast on the second.
        kc(K_IDLE);
        kc(K_SOF);
        for (int i = 1; i <= 8; i++) db(8'(i));
        kc(K_EOF);
        drain();
        chk("t1_words", got.size(), 2);
        chk("t1_w0", got_at(0), {32'h04030201, 4'hF, 1'b0, 1'b0});
        chk("t1_w1", got_at(1), {32'h08070605, 4'hF, 1'b1, 1'b0});
        chk("t1_frame_bytes", frame_bytes, 32'd8);
        chk("t1_frame_cnt", frame_cnt, 16'd1);

        // Partial last word.
        do_reset();
        kc(K_SOF);
        db(8'hAA); db(8'hBB); db(8'hCC); db(8'hDD); db(8'hEE);
        kc(K_EOF);
        drain();
        chk("t2_w0", got_at(0), {32'hDDCCBBAA, 4'hF, 1'b0, 1'b0});
        chk("t2_w1", got_at(1), {32'h000000EE, 4'h1, 1'b1, 1'b0});

        // Bad K-char aborts the frame; trailing byte is discarded.
        do_reset();
        kc(K_SOF);
        db(8'h11); db(8'h22);
        kc(8'hF7);
        db(8'h33);
        drain();
        chk("t3_words", got.size(), 1);
        chk("t3_w0", got_at(0), {32'h00002211, 4'h3, 1'b1, 1'b1});
        chk("t3_err_cnt", err_cnt, 16'd1);
        chk("t3_frame_cnt", frame_cnt, 16'd0);

        // Runt, then a short frame failing the length check.
        do_reset();
        kc(K_SOF);
        kc(K_EOF);
        drain();
        chk("t4_runt_words", got.size(), 0);
        chk("t4_runt_err", err_cnt, 16'd1);
        exp_bytes = 32'd4;
        kc(K_SOF);
        db(8'h01); db(8'h02); db(8'h03);
        kc(K_EOF);
        drain();
        chk("t4_w0", got_at(0), {32'h00030201, 4'h7, 1'b1, 1'b0});
        chk("t4_len_err", len_err, 1'b1);
        chk("t4_err_cnt", err_cnt, 16'd2);
        exp_bytes = '0;

        // Overflow with the sink stalled.
        do_reset();
        model_on   = 1'b0;
        ready_mode = 2;
        kc(K_SOF);
        for (int i = 0; i < 20; i++) db(8'(i + 1));
        chk("ovf_before", fifo_overflow, 1'b0);
        for (int i = 20; i < 40; i++) db(8'(i + 1));
        kc(K_EOF);
        repeat (2) @(posedge sys_clk);
        #1;
        chk("ovf_sticky", fifo_overflow, 1'b1);
        chk("ovf_tvalid_held", m_axis.tvalid, 1'b1);
        ready_mode = 0;
        repeat (20) @(posedge sys_clk);
        #1;
        chk("ovf_words", got.size(), 4);
        for (int w = 0; w < 4; w++)
            chk("ovf_word", got_at(w), {8'(4*w+4), 8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 4'hF, 2'b00});
        model_on = 1'b1;

        // Asynchronous reset in the middle of a frame.
        do_reset();
        kc(K_SOF); db(8'h01); kc(K_EOF);
        drain();
        ready_mode = 2;
        kc(K_SOF);
        for (int i = 1; i <= 6; i++) db(8'(i));
        repeat (2) @(posedge sys_clk);
        #1;
        chk("pre_rst_tvalid", m_axis.tvalid, 1'b1);
        chk("pre_rst_frame_cnt", frame_cnt, 16'd1);
        #2;
        sys_rst_n = 1'b0;
        model_clear();
        #1;
        chk("mid_rst_tvalid", m_axis.tvalid, 1'b0);
        chk("mid_rst_counts", {frame_cnt, err_cnt, frame_bytes}, 64'd0);
        do_reset();
        ready_mode = 0;
        kc(K_SOF);
        for (int i = 1; i <= 5; i++) db(8'(i));
        kc(K_EOF);
        drain();
        chk("post_rst_w0", got_at(0), {32'h04030201, 4'hF, 1'b0, 1'b0});
        chk("post_rst_w1", got_at(1), {32'h00000005, 4'h1, 1'b1, 1'b0});
        chk("post_rst_frame_cnt", frame_cnt, 16'd1);

        // Randomized byte stream under random backpressure.
        do_reset();
        for (int s = 0; s < 8; s++) begin
            exp_bytes  = $urandom_range(0, 2) == 0 ? 32'd0 : 32'($urandom_range(1, 9));
            ready_mode = 1;
            for (int n = 0; n < 300; n++) begin
                int r;
                r = $urandom_range(0, 99);
                if (r < 55) db(8'($urandom_range(0, 255)));
                else if (r < 63) kc(K_SOF);
                else if (r < 70) kc(K_EOF);
                else if (r < 73) kc(bad_k[$urandom_range(0, 4)]);
                else if (r < 83) kc(K_IDLE);
                else put(1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            end
            kc(K_EOF);
            drain();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
